par_to_ser_tx: RTL and testbench

//   TX PHY serializer that sits directly downstream of the 2:1 byte mux.
//   It takes one byte per symbol slot with a valid flag and shifts it out
//   MSB-first, one bit per clk, on a single serial line.

---
 rtl/par_to_ser_tx.sv | 133 +++++++++++++
 tb/tb_par_to_ser_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/par_to_ser_tx.sv
// -----------------------------------------------------------------------------
// par_to_ser_tx
//   TX PHY serializer that sits directly after the 2:1 byte mux. It loads one
//   symbol per WIDTH-cycle slot and shifts it out MSB-first, one bit per clk.
//   After reset it sends SYNC_COUNT idle (COM) symbols before it accepts any
//   data. In normal operation, a slot with no byte offered carries IDLE_SYMBOL.
//
// Ports
//   clk        in   1      single clock, posedge
//   reset      in   1      asynchronous active-low reset (0 = in reset)
//   data_in    in   WIDTH  byte from the upstream mux
//   valid_in   in   1      data_in holds a byte to send
//   ready_out  out  1      load slot open; byte moves when valid_in && ready_out
//   data_out   out  1      serial bit, MSB of the current symbol first
//   is_data    out  1      current symbol is a data byte, not idle
//   sync_done  out  1      sync phase complete; held until the next reset
// -----------------------------------------------------------------------------
module par_to_ser_tx #(
  parameter int unsigned       WIDTH       = 8,
  parameter logic [WIDTH-1:0]  IDLE_SYMBOL = 8'hBC,
  parameter int unsigned       SYNC_COUNT  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             is_data,
  output logic             sync_done
);

  localparam int unsigned      CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned      SYNC_W    = $clog2(SYNC_COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_COUNT);

  typedef enum logic {
    SYNC,
    ACTIVE
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
  logic [SYNC_W-1:0] sync_cnt, sync_cnt_next;
  logic [WIDTH-1:0]  shreg, shreg_next;
  logic              is_data_next;
  logic              sync_done_next;
  logic              load;
  logic [SYNC_W-1:0] sync_cnt_inc;

  // The slot boundary: the last bit of the current symbol is on the line, so
  // the coming edge loads the next symbol. Reset value WIDTH-1 makes the first
  // edge after release a load.
  assign load         = (bit_cnt == LAST_BIT);
  assign sync_cnt_inc = sync_cnt + SYNC_W'(1);

  // Purely a decode of registered state, so upstream never sees a path from
  // its own valid_in back into ready_out.
  assign ready_out = (state == ACTIVE) && load;

  // Register output: no combinational path from the inputs to the line.
  assign data_out  = shreg[WIDTH-1];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves one unassigned and no latch is inferred.
    state_next     = state;
    sync_cnt_next  = sync_cnt;
    sync_done_next = sync_done;
    is_data_next   = is_data;
    shreg_next     = shreg << 1;
    bit_cnt_next   = load ? '0 : bit_cnt + CNT_W'(1);

    if (load) begin
      unique case (state)
        SYNC: begin
          shreg_next   = IDLE_SYMBOL;
          is_data_next = 1'b0;
          // sync_cnt saturates: once it reaches SYNC_COUNT the FSM has left
          // SYNC for good, so it never counts past the limit.
          if (sync_cnt != SYNC_LAST) begin
            sync_cnt_next = sync_cnt_inc;
          end
          if (sync_cnt_inc == SYNC_LAST) begin
            state_next     = ACTIVE;
            sync_done_next = 1'b1;
          end
        end
        ACTIVE: begin
          // An empty slot is filled with idle and consumes nothing upstream.
          if (valid_in) begin
            shreg_next   = data_in;
            is_data_next = 1'b1;
          end else begin
            shreg_next   = IDLE_SYMBOL;
            is_data_next = 1'b0;
          end
        end
        default: begin
          state_next = SYNC;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SYNC;
      bit_cnt   <= LAST_BIT;
      sync_cnt  <= '0;
      shreg     <= '0;
      is_data   <= 1'b0;
      sync_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values, independent of statement order.
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      sync_cnt  <= sync_cnt_next;
      shreg     <= shreg_next;
      is_data   <= is_data_next;
      sync_done <= sync_done_next;
    end
  end

endmodule

// File: tb/tb_par_to_ser_tx.sv
// -----------------------------------------------------------------------------
// tb_par_to_ser_tx
//   Self-checking bench for par_to_ser_tx. A reference model driven only by
//   the number of clock edges since reset release decides which symbol each
//   slot carries and which bit of it must be on the line. Table-driven slots,
//   hand-written corner sequences and random stimulus all run through it.
// -----------------------------------------------------------------------------
module tb_par_to_ser_tx;

  localparam int         W    = 8;
  localparam logic [7:0] IDLE = 8'hBC;
  localparam int         SC   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       is_data;
  logic       sync_done;

  par_to_ser_tx #(
    .WIDTH      (W),
    .IDLE_SYMBOL(IDLE),
    .SYNC_COUNT (SC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .data_out (data_out),
    .is_data  (is_data),
    .sync_done(sync_done)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;

  // Reference model state: edges since release, and the symbol of the slot.
  int         edge_n;
  logic [7:0] m_sym;
  logic       m_isd;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] exp_sym;
    logic       exp_isd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check ready_out before the edge, advance the
  // model on the edge, then check the registered outputs just after it.
  task automatic tick(input logic v, input logic [7:0] d);
    int pos;
    valid_in = v;
    data_in  = d;
    #1;
    check("ready_out", 32'(ready_out), 32'((edge_n % W) == 0 && (edge_n / W) >= SC));
    @(posedge clk);
    if ((edge_n % W) == 0) begin
      if ((edge_n / W) < SC || !v) begin
        m_sym = IDLE;
        m_isd = 1'b0;
      end else begin
        m_sym = d;
        m_isd = 1'b1;
      end
    end
    #1;
    pos = W - 1 - (edge_n % W);
    check("data_out",  32'(data_out),  32'(m_sym[pos]));
    check("is_data",   32'(is_data),   32'(m_isd));
    check("sync_done", 32'(sync_done), 32'(edge_n >= (SC - 1) * W));
    edge_n++;
  endtask

  // One full symbol slot with inputs held; returns the serialized symbol,
  // is_data seen on its first bit and the number of ready_out pulses.
  task automatic run_slot(input logic v, input logic [7:0] d,
                          output logic [7:0] sym, output logic isd, output int rdy);
    sym = '0;
    isd = 1'b0;
    rdy = 0;
    for (int i = 0; i < W; i++) begin
      if (ready_out) rdy++;
      tick(v, d);
      sym = {sym[6:0], data_out};
      if (i == 0) isd = is_data;
    end
  endtask

  // Assert reset (asynchronously, mid-cycle), confirm outputs clear at once,
  // then release on a falling edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_data_out",  32'(data_out),  32'(0));
    check("rst_is_data",   32'(is_data),   32'(0));
    check("rst_sync_done", 32'(sync_done), 32'(0));
    check("rst_ready_out", 32'(ready_out), 32'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset  = 1'b1;
    edge_n = 0;
    m_sym  = '0;
    m_isd  = 1'b0;
  endtask

  initial begin
    logic [7:0] sym;
    logic       isd;
    int         rdy;

    vecs[0] = '{1'b1, 8'hA5, 8'hA5, 1'b1};
    vecs[1] = '{1'b0, 8'h00, 8'hBC, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 8'hFF, 8'hFF, 1'b1};
    vecs[4] = '{1'b1, 8'h3C, 8'h3C, 1'b1};
    vecs[5] = '{1'b0, 8'h77, 8'hBC, 1'b0};
    vecs[6] = '{1'b1, 8'hBC, 8'hBC, 1'b1};
    vecs[7] = '{1'b1, 8'h01, 8'h01, 1'b1};

    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    edge_n   = 0;
    m_sym    = '0;
    m_isd    = 1'b0;
    #2;
    do_reset();

    // Sync phase with nothing offered: four idle symbols, no ready_out.
    for (int s = 0; s < SC; s++) begin
      run_slot(1'b0, 8'h00, sym, isd, rdy);
      check("sync_sym", 32'(sym), 32'(8'hBC));
      check("sync_isd", 32'(isd), 32'(0));
      check("sync_rdy", 32'(rdy), 32'(0));
    end
    check("sync_done_after_sync", 32'(sync_done), 32'(1));

    // Table: single byte, idle gap, back-to-back bytes, data equal to COM.
    for (int i = 0; i < 8; i++) begin
      run_slot(vecs[i].v, vecs[i].d, sym, isd, rdy);
      check("vec_sym", 32'(sym), 32'(vecs[i].exp_sym));
      check("vec_isd", 32'(isd), 32'(vecs[i].exp_isd));
      check("vec_rdy", 32'(rdy), 32'(1));
    end

    // valid_in pulsed only while bit_cnt==3 (fifth cycle of the slot).
    sym = '0;
    for (int i = 0; i < W; i++) begin
      tick(i == 4, 8'h66);
      sym = {sym[6:0], data_out};
      if (i == 0) isd = is_data;
    end
    check("midslot_sym", 32'(sym), 32'(8'hBC));
    check("midslot_isd", 32'(isd), 32'(0));
    run_slot(1'b0, 8'h66, sym, isd, rdy);
    check("midslot_next_sym", 32'(sym), 32'(8'hBC));

    // valid_in held during SYNC: ignored until the first ACTIVE slot.
    do_reset();
    for (int s = 0; s < SC; s++) begin
      run_slot(1'b1, 8'h55, sym, isd, rdy);
      check("sync_valid_sym", 32'(sym), 32'(8'hBC));
      check("sync_valid_rdy", 32'(rdy), 32'(0));
    end
    run_slot(1'b1, 8'h55, sym, isd, rdy);
    check("first_active_sym", 32'(sym), 32'(8'h55));
    check("first_active_isd", 32'(isd), 32'(1));
    check("first_active_rdy", 32'(rdy), 32'(1));

    // Reset in the middle of a data byte: outputs clear, full sync repeats.
    for (int i = 0; i < 4; i++) tick(1'b1, 8'hA5);
    do_reset();
    for (int s = 0; s < SC; s++) begin
      run_slot(1'b1, 8'hA5, sym, isd, rdy);
      check("resync_sym", 32'(sym), 32'(8'hBC));
      check("resync_rdy", 32'(rdy), 32'(0));
    end
    run_slot(1'b1, 8'hA5, sym, isd, rdy);
    check("resync_data_sym", 32'(sym), 32'(8'hA5));

    // Random traffic, changing every cycle, against the model.
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
